regport_rr_arbiter: RTL and testbench

- Shares one downstream register port (the NPIO/radio RegPort: wr_req/addr/data, rd_req/addr, rd_resp/data) among NUM_MASTERS upstream requesters.
- Upstream requesters are the AXI-lite bridge, the radio cores and the PS GPIO block.
- Each master gets a one-deep request slot, serviced round-robin, with only one transaction in flight downstream.
- A read response is routed back only to the master that issued the read.

---
 rtl/regport_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_regport_rr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regport_rr_arbiter.sv
// Round-robin arbiter sharing one downstream RegPort among NUM_MASTERS requesters.
// Optional read timeout is built when REGPORT_ARB_TIMEOUT_EN is defined.
module regport_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int REG_AWIDTH  = 32,
    parameter int REG_DWIDTH  = 32,
    parameter int RD_TIMEOUT  = 1023
) (
    input  logic                              bus_clk,
    input  logic                              bus_rst,
    input  logic [NUM_MASTERS-1:0]            m_wr_req,
    input  logic [NUM_MASTERS*REG_AWIDTH-1:0] m_wr_addr,
    input  logic [NUM_MASTERS*REG_DWIDTH-1:0] m_wr_data,
    input  logic [NUM_MASTERS-1:0]            m_rd_req,
    input  logic [NUM_MASTERS*REG_AWIDTH-1:0] m_rd_addr,
    output logic [NUM_MASTERS-1:0]            m_rd_resp,
    output logic [REG_DWIDTH-1:0]             m_rd_data,
    output logic [NUM_MASTERS-1:0]            m_rdy,
    output logic                              s_wr_req,
    output logic [REG_AWIDTH-1:0]             s_wr_addr,
    output logic [REG_DWIDTH-1:0]             s_wr_data,
    output logic                              s_rd_req,
    output logic [REG_AWIDTH-1:0]             s_rd_addr,
    input  logic                              s_rd_resp,
    input  logic [REG_DWIDTH-1:0]             s_rd_data,
    output logic [15:0]                       drop_cnt,
    input  logic                              stat_clr,
    output logic                              timeout_sticky
);
    // state   | meaning
    // IDLE    | nothing in flight; grant next full slot after the RR pointer
    // ISSUE   | one-cycle downstream strobe for the granted slot
    // WAIT_RD | read outstanding; waiting for s_rd_resp (or timeout)
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
`ifdef REGPORT_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, gnt_q, gnt_idx, cand;
    logic                   gnt_found;
    logic [NUM_MASTERS-1:0] slot_full, slot_wr, free_vec;
    logic [REG_AWIDTH-1:0]  slot_addr [NUM_MASTERS];
    logic [REG_DWIDTH-1:0]  slot_data [NUM_MASTERS];
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   cur_wr, tmo_hit, rd_done, drop_any;

    assign m_rdy    = ~slot_full;
    assign cur_wr   = slot_wr[gnt_q];
    assign tmo_hit  = TMO_EN && (state_q == WAIT_RD) && !s_rd_resp && (tmo_cnt == '0);
    assign rd_done  = ((state_q == WAIT_RD) && s_rd_resp) || tmo_hit;
    // a simultaneous write+read from one master keeps the write and counts the read as dropped
    assign drop_any = |((slot_full & (m_wr_req | m_rd_req)) | (~slot_full & m_wr_req & m_rd_req));

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_MASTERS);
            if (!gnt_found && slot_full[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        free_vec = '0;
        if (((state_q == ISSUE) && cur_wr) || rd_done) begin
            free_vec[gnt_q] = 1'b1;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = ISSUE;
            ISSUE:   state_d = cur_wr ? IDLE : WAIT_RD;
            WAIT_RD: if (rd_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_wr_req = (state_q == ISSUE) && cur_wr;
        s_rd_req = (state_q == ISSUE) && !cur_wr;
    end

    // slot payload needs no reset; slot_full qualifies it
    always_ff @(posedge bus_clk) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!slot_full[i] && (m_wr_req[i] || m_rd_req[i])) begin
                slot_addr[i] <= m_wr_req[i] ? m_wr_addr[i*REG_AWIDTH +: REG_AWIDTH]
                                            : m_rd_addr[i*REG_AWIDTH +: REG_AWIDTH];
                slot_data[i] <= m_wr_data[i*REG_DWIDTH +: REG_DWIDTH];
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            slot_full      <= '0;
            slot_wr        <= '0;
            ptr_q          <= IDX_W'(NUM_MASTERS - 1);
            gnt_q          <= '0;
            s_wr_addr      <= '0;
            s_wr_data      <= '0;
            s_rd_addr      <= '0;
            m_rd_resp      <= '0;
            m_rd_data      <= '0;
            tmo_cnt        <= '0;
            drop_cnt       <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            m_rd_resp <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (free_vec[i]) begin
                    slot_full[i] <= 1'b0;
                end else if (!slot_full[i] && (m_wr_req[i] || m_rd_req[i])) begin
                    slot_full[i] <= 1'b1;
                    slot_wr[i]   <= m_wr_req[i];
                end
            end

            if ((state_q == IDLE) && gnt_found) begin
                ptr_q <= gnt_idx;
                gnt_q <= gnt_idx;
                if (slot_wr[gnt_idx]) begin
                    s_wr_addr <= slot_addr[gnt_idx];
                    s_wr_data <= slot_data[gnt_idx];
                end else begin
                    s_rd_addr <= slot_addr[gnt_idx];
                end
            end

            if (state_q == ISSUE) begin
                tmo_cnt <= TMO_W'(RD_TIMEOUT - 1);
            end else if ((state_q == WAIT_RD) && (tmo_cnt != '0)) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end

            if (rd_done) begin
                m_rd_resp[gnt_q] <= 1'b1;
                m_rd_data        <= s_rd_resp ? s_rd_data : '1;
            end

            if (stat_clr) begin
                drop_cnt       <= '0;
                timeout_sticky <= 1'b0;
            end else begin
                if (drop_any && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
                if (tmo_hit) timeout_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regport_rr_arbiter.sv
// Scoreboard bench for regport_rr_arbiter: downstream strobes and read responses
// are queued when stimulus is driven and compared when the DUT produces them.
module tb_regport_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            bus_clk = 1'b0;
    logic            bus_rst = 1'b1;
    logic [N-1:0]    m_wr_req = '0;
    logic [N*AW-1:0] m_wr_addr = '0;
    logic [N*DW-1:0] m_wr_data = '0;
    logic [N-1:0]    m_rd_req = '0;
    logic [N*AW-1:0] m_rd_addr = '0;
    logic [N-1:0]    m_rd_resp;
    logic [DW-1:0]   m_rd_data;
    logic [N-1:0]    m_rdy;
    logic            s_wr_req, s_rd_req;
    logic [AW-1:0]   s_wr_addr, s_rd_addr;
    logic [DW-1:0]   s_wr_data;
    logic            s_rd_resp = 1'b0;
    logic [DW-1:0]   s_rd_data = '0;
    logic [15:0]     drop_cnt;
    logic            stat_clr = 1'b0;
    logic            timeout_sticky;

    regport_rr_arbiter #(
        .NUM_MASTERS(N), .REG_AWIDTH(AW), .REG_DWIDTH(DW), .RD_TIMEOUT(16)
    ) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr),
        .m_rd_resp(m_rd_resp), .m_rd_data(m_rd_data), .m_rdy(m_rdy),
        .s_wr_req(s_wr_req), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr),
        .s_rd_resp(s_rd_resp), .s_rd_data(s_rd_data),
        .drop_cnt(drop_cnt), .stat_clr(stat_clr), .timeout_sticky(timeout_sticky)
    );

    always #5 bus_clk = ~bus_clk;

    int cyc = 0;
    always @(posedge bus_clk) cyc <= cyc + 1;

    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } ds_t;
    typedef struct { logic [N-1:0] hot; logic [DW-1:0] data; int cyc; } rsp_t;
    ds_t  ds_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge bus_clk);
    endtask

    task automatic clear_req();
        m_wr_req = '0;
        m_rd_req = '0;
    endtask

    task automatic put_wr(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_wr_req[m]        = 1'b1;
        m_wr_addr[m*AW +: AW] = a;
        m_wr_data[m*DW +: DW] = d;
    endtask

    task automatic put_rd(input int m, input logic [AW-1:0] a);
        m_rd_req[m]        = 1'b1;
        m_rd_addr[m*AW +: AW] = a;
    endtask

    task automatic exp_ds(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
        ds_t e;
        e.wr = wr; e.addr = a; e.data = d; e.cyc = c;
        ds_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic [N-1:0] hot, input logic [DW-1:0] d, input int c);
        rsp_t r;
        r.hot = hot; r.data = d; r.cyc = c;
        rsp_q.push_back(r);
    endtask

    task automatic do_reset();
        bus_rst = 1'b1;
        step();
        step();
        bus_rst = 1'b0;
    endtask

    task automatic wait_all_rdy(input int budget);
        int k;
        k = 0;
        settle();
        while (m_rdy !== '1 && k < budget) begin
            step();
            settle();
            k++;
        end
        if (m_rdy !== '1) check_val("wait_rdy_timeout", m_rdy, 4'hF);
    endtask

    always @(negedge bus_clk) begin
        ds_t  e;
        rsp_t r;
        if (s_wr_req === 1'b1 || s_rd_req === 1'b1) begin
            if (ds_q.size() == 0) begin
                check_val("ds_unexpected", {s_wr_req, s_rd_req}, 2'b00);
            end else begin
                e = ds_q.pop_front();
                check_val("ds_op", {s_wr_req, s_rd_req}, e.wr ? 2'b10 : 2'b01);
                check_val("ds_addr", e.wr ? s_wr_addr : s_rd_addr, e.addr);
                if (e.wr) check_val("ds_data", s_wr_data, e.data);
                check_val("ds_cycle", cyc, e.cyc);
            end
        end
        if (m_rd_resp != '0) begin
            if (rsp_q.size() == 0) begin
                check_val("rsp_unexpected", m_rd_resp, '0);
            end else begin
                r = rsp_q.pop_front();
                check_val("rsp_onehot", m_rd_resp, r.hot);
                check_val("rsp_data", m_rd_data, r.data);
                check_val("rsp_cycle", cyc, r.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        step();
        step();
        step();
        bus_rst = 1'b0;
        settle();
        check_val("rst_rdy", m_rdy, 4'hF);
        check_val("rst_rd_resp", m_rd_resp, 0);
        check_val("rst_strobes", {s_wr_req, s_rd_req}, 0);
        check_val("rst_drop_cnt", drop_cnt, 0);
        check_val("rst_sticky", timeout_sticky, 0);
        check_val("rst_s_wr_addr", s_wr_addr, 0);

        // single uncontended write from master 1
        step();
        t = cyc;
        put_wr(1, 32'h40, 32'h1234_5678);
        exp_ds(1'b1, 32'h40, 32'h1234_5678, t + 2);
        settle(); check_val("wr1_rdy_t0", m_rdy[1], 1);
        step(); clear_req();
        settle(); check_val("wr1_rdy_t1", m_rdy[1], 0);
        step();
        settle(); check_val("wr1_rdy_t2", m_rdy[1], 0);
        step();
        settle(); check_val("wr1_rdy_t3", m_rdy[1], 1);
        check_val("wr_addr_hold", s_wr_addr, 32'h40);

        // all four masters at once after reset: order 0,1,2,3 every 2 cycles
        do_reset();
        t = cyc;
        for (int m = 0; m < N; m++) begin
            put_wr(m, 32'h100 + 32'(m * 4), 32'hA0 + 32'(m));
            exp_ds(1'b1, 32'h100 + 32'(m * 4), 32'hA0 + 32'(m), t + 2 + 2 * m);
        end
        step(); clear_req();
        wait_all_rdy(20);
        step();
        t = cyc;
        put_wr(3, 32'h1FC, 32'hB3);
        put_wr(0, 32'h1F0, 32'hB0);
        exp_ds(1'b1, 32'h1F0, 32'hB0, t + 2);
        exp_ds(1'b1, 32'h1FC, 32'hB3, t + 4);
        step(); clear_req();
        wait_all_rdy(20);

        // read from master 2 answered four cycles after s_rd_req
        step();
        t = cyc;
        put_rd(2, 32'h80);
        exp_ds(1'b0, 32'h80, '0, t + 2);
        step(); clear_req();
        repeat (5) step();
        s_rd_resp = 1'b1;
        s_rd_data = 32'hCAFE_0001;
        exp_rsp(4'b0100, 32'hCAFE_0001, t + 7);
        settle(); check_val("rd_slot_busy", m_rdy[2], 0);
        step();
        s_rd_resp = 1'b0;
        s_rd_data = '0;
        settle(); check_val("rd_slot_freed", m_rdy[2], 1);
        check_val("rd_resp_bits", m_rd_resp, 4'b0100);
        step();
        settle(); check_val("rd_resp_single", m_rd_resp, 0);
        s_rd_resp = 1'b1;
        s_rd_data = 32'hDEAD_0000;
        step();
        s_rd_resp = 1'b0;
        settle(); check_val("rd_resp_spurious", m_rd_resp, 0);

        // drops: several in one cycle count once, stat_clr wins over increment
        step();
        t = cyc;
        put_wr(0, 32'h10, 32'h11);
        put_wr(1, 32'h14, 32'h22);
        exp_ds(1'b1, 32'h10, 32'h11, t + 2);
        exp_ds(1'b1, 32'h14, 32'h22, t + 4);
        step(); clear_req();
        put_wr(0, 32'h50, 32'h55);
        put_wr(1, 32'h54, 32'h66);
        put_wr(2, 32'h208, 32'h2222);
        put_rd(2, 32'h20C);
        exp_ds(1'b1, 32'h208, 32'h2222, t + 6);
        settle(); check_val("drop_before", drop_cnt, 0);
        step(); clear_req();
        settle(); check_val("drop_multi_one", drop_cnt, 1);
        stat_clr = 1'b1;
        put_wr(0, 32'h58, 32'h77);
        step(); clear_req();
        stat_clr = 1'b0;
        settle(); check_val("drop_clr_prio", drop_cnt, 0);
        put_wr(1, 32'h5C, 32'h88);
        step(); clear_req();
        settle(); check_val("drop_after_clr", drop_cnt, 1);
        wait_all_rdy(20);

`ifdef REGPORT_ARB_TIMEOUT_EN
        // downstream never answers: timeout response after RD_TIMEOUT cycles in WAIT_RD
        step();
        t = cyc;
        put_rd(0, 32'h200);
        exp_ds(1'b0, 32'h200, '0, t + 2);
        exp_rsp(4'b0001, 32'hFFFF_FFFF, t + 19);
        step(); clear_req();
        repeat (17) step();
        settle(); check_val("tmo_sticky_before", timeout_sticky, 0);
        step();
        s_rd_resp = 1'b1;
        s_rd_data = 32'h1234_0000;
        settle(); check_val("tmo_sticky_set", timeout_sticky, 1);
        step();
        s_rd_resp = 1'b0;
        stat_clr  = 1'b1;
        settle(); check_val("tmo_late_resp", m_rd_resp, 0);
        step();
        stat_clr = 1'b0;
        settle(); check_val("tmo_sticky_clr", timeout_sticky, 0);
`endif

        // reset during WAIT_RD with two slots full
        do_reset();
        t = cyc;
        put_rd(1, 32'h300);
        put_wr(3, 32'h304, 32'h55);
        exp_ds(1'b0, 32'h300, '0, t + 2);
        step(); clear_req();
        repeat (4) step();
        bus_rst = 1'b1;
        step();
        bus_rst   = 1'b0;
        s_rd_resp = 1'b1;
        s_rd_data = 32'hBAD0_BAD0;
        put_wr(3, 32'h404, 32'hC3);
        put_wr(0, 32'h400, 32'hC0);
        exp_ds(1'b1, 32'h400, 32'hC0, t + 8);
        exp_ds(1'b1, 32'h404, 32'hC3, t + 10);
        settle();
        check_val("rst_mid_rdy", m_rdy, 4'hF);
        check_val("rst_mid_rd_resp", m_rd_resp, 0);
        check_val("rst_mid_strobes", {s_wr_req, s_rd_req}, 0);
        step(); clear_req();
        s_rd_resp = 1'b0;
        settle(); check_val("rst_late_resp", m_rd_resp, 0);
        wait_all_rdy(20);

        repeat (4) step();
        settle();
        check_val("ds_q_drained", ds_q.size(), 0);
        check_val("rsp_q_drained", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
